// File: rtl/dm_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter.
package dm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        WR   = 2'd2
    } state_e;

    localparam int NPORT = 2;

    function automatic logic [31:0] be2mask(input logic [3:0] be);
        logic [31:0] mask;
        mask = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            mask[8*i +: 8] = {8{be[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// Requester handshake, response and memory-port signals of dm_arbiter.
interface dm_arbiter_if;
    import dm_arb_pkg::*;

    logic [NPORT-1:0] req_valid;
    logic [NPORT-1:0] req_ready;
    logic [NPORT-1:0] req_we;
    logic [31:0]      req_addr0;
    logic [31:0]      req_addr1;
    logic [31:0]      req_wdata0;
    logic [31:0]      req_wdata1;
    logic [3:0]       req_be0;
    logic [3:0]       req_be1;
    logic [31:0]      req_pc0;
    logic [31:0]      req_pc1;
    logic [NPORT-1:0] rsp_valid;
    logic [31:0]      rsp_rdata;
    logic             rsp_err;
    logic [31:0]      m_A;
    logic [31:0]      m_WD;
    logic             m_RE;
    logic             m_WE;
    logic [31:0]      m_PC;
    logic [31:0]      m_RD;

    modport slave (
        input  req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1,
               req_be0, req_be1, req_pc0, req_pc1, m_RD,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               m_A, m_WD, m_RE, m_WE, m_PC
    );

    modport master (
        output req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1,
               req_be0, req_be1, req_pc0, req_pc1, m_RD,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               m_A, m_WD, m_RE, m_WE, m_PC
    );

endinterface

// File: rtl/dm_arb_rr.sv
// Two-input round-robin picker: combinational grant, pointer updated on grant.
module dm_arb_rr (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       upd_i,
    output logic [1:0] gnt_o,
    output logic       id_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        id_o  = 1'b0;
        gnt_o = '0;
        unique case (req_i)
            2'b01:   id_o = 1'b0;
            2'b10:   id_o = 1'b1;
            2'b11:   id_o = ~last_q;
            default: id_o = 1'b0;
        endcase
        if (|req_i) begin
            gnt_o = id_o ? 2'b10 : 2'b01;
        end
        last_d = upd_i ? id_o : last_q;
    end

    // Pointer starts at port 1 so port 0 wins the first conflict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter and RMW sequencer in front of the word memory.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int DM_AW = 10
) (
    input  logic        clk,
    input  logic        Reset_n,
    dm_arbiter_if.slave bus
);

    state_e      state_q, state_d;
    logic        id_q, id_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        we_q, we_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] merged_q, merged_d;
    logic [1:0]  rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic [1:0]  gnt;
    logic        gnt_id;
    logic [1:0]  ready;
    logic        xfer;
    logic        in_range;
    logic        done;
    logic        m_re, m_we;
    logic [31:0] m_wd;
    logic [31:0] mask;

    assign ready = (state_q == IDLE) ? gnt : '0;
    assign xfer  = |(bus.req_valid & ready);

    dm_arb_rr u_rr (
        .clk   (clk),
        .rst_n (Reset_n),
        .req_i (bus.req_valid),
        .upd_i (xfer),
        .gnt_o (gnt),
        .id_o  (gnt_id)
    );

    assign in_range = (addr_q[31:DM_AW+2] == '0);
    assign mask     = be2mask(be_q);

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        we_d        = we_q;
        pc_d        = pc_q;
        merged_d    = merged_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        done        = 1'b0;
        m_re        = 1'b0;
        m_we        = 1'b0;
        m_wd        = '0;

        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    id_d    = gnt_id;
                    addr_d  = (gnt_id ? bus.req_addr1 : bus.req_addr0) & 32'hFFFF_FFFC;
                    wdata_d = gnt_id ? bus.req_wdata1 : bus.req_wdata0;
                    be_d    = gnt_id ? bus.req_be1 : bus.req_be0;
                    we_d    = bus.req_we[gnt_id];
                    pc_d    = gnt_id ? bus.req_pc1 : bus.req_pc0;
                    state_d = ACC;
                end
            end
            ACC: begin
                if (!in_range) begin
                    done = 1'b1;
                end else if (!we_q) begin
                    m_re        = 1'b1;
                    rsp_rdata_d = bus.m_RD;
                    done        = 1'b1;
                end else if (be_q == 4'hF) begin
                    m_we = 1'b1;
                    m_wd = wdata_q;
                    done = 1'b1;
                end else if (be_q == 4'h0) begin
                    done = 1'b1;
                end else begin
                    m_re     = 1'b1;
                    merged_d = (bus.m_RD & ~mask) | (wdata_q & mask);
                    state_d  = WR;
                end
                rsp_err_d = done ? !in_range : rsp_err_q;
            end
            WR: begin
                m_we      = 1'b1;
                m_wd      = merged_q;
                rsp_err_d = 1'b0;
                done      = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (done) begin
            state_d             = IDLE;
            rsp_valid_d[id_q]   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            id_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            we_q        <= 1'b0;
            pc_q        <= '0;
            merged_q    <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            we_q        <= we_d;
            pc_q        <= pc_d;
            merged_q    <= merged_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.req_ready = ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.m_A       = (state_q == IDLE) ? '0 : addr_q;
    assign bus.m_PC      = (state_q == IDLE) ? '0 : pc_q;
    assign bus.m_RE      = m_re;
    assign bus.m_WE      = m_we;
    assign bus.m_WD      = m_wd;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural word memory.
module tb_dm_arbiter;

    logic clk;
    logic Reset_n;
    int   cyc;
    int   n_cmp;
    int   n_fail;

    dm_arbiter_if bus ();

    dm_arbiter #(.DM_AW(10)) dut (
        .clk     (clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    logic [31:0] mem [0:1023];

    always @(posedge clk) begin
        if (bus.m_WE) mem[bus.m_A[11:2]] <= bus.m_WD;
    end
    assign bus.m_RD = mem[bus.m_A[11:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Issue one request on port p; returns latency (accept edge counted as cycle 1) and activity.
    task automatic do_req(input int p, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] be,
                          output int lat, output int nre, output int nwe,
                          output logic [1:0] rv, output logic [31:0] rd,
                          output logic err, output logic ok);
        logic acc;
        logic done;
        int   a;
        acc = 1'b0; done = 1'b0; lat = 0; nre = 0; nwe = 0;
        rv = '0; rd = '0; err = 1'b0; a = 0;
        bus.req_we[p] = we;
        if (p == 0) begin
            bus.req_addr0 = addr; bus.req_wdata0 = wd; bus.req_be0 = be; bus.req_pc0 = 32'h100 + addr;
        end else begin
            bus.req_addr1 = addr; bus.req_wdata1 = wd; bus.req_be1 = be; bus.req_pc1 = 32'h200 + addr;
        end
        bus.req_valid[p] = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            if (bus.req_ready[p]) acc = 1'b1;
        end
        @(posedge clk); #1;
        a = cyc;
        bus.req_valid[p] = 1'b0;
        for (int i = 0; i < 10 && acc && !done; i++) begin
            @(negedge clk);
            nre += int'(bus.m_RE);
            nwe += int'(bus.m_WE);
            if (|bus.rsp_valid) begin
                done = 1'b1;
                lat  = cyc - a + 1;
                rv   = bus.rsp_valid;
                rd   = bus.rsp_rdata;
                err  = bus.rsp_err;
            end
        end
        @(posedge clk); #1;
        ok = acc && done;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        bus.req_valid = '0; bus.req_we = '0;
        bus.req_addr0 = '0; bus.req_addr1 = '0; bus.req_wdata0 = '0; bus.req_wdata1 = '0;
        bus.req_be0 = '0; bus.req_be1 = '0; bus.req_pc0 = '0; bus.req_pc1 = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.m_RE, bus.m_WE} !== 7'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 0", {bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.m_RE, bus.m_WE});
        end
        n_cmp++;
        if ({bus.rsp_rdata, bus.m_A, bus.m_WD, bus.m_PC} !== 128'b0) begin
            n_fail++; $display("FAIL reset_data: rdata=%h A=%h WD=%h PC=%h want 0", bus.rsp_rdata, bus.m_A, bus.m_WD, bus.m_PC);
        end
        Reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_full_store_load();
        int lat, nre, nwe; logic [1:0] rv; logic [31:0] rd; logic err, ok;
        do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, nre, nwe, rv, rd, err, ok);
        n_cmp++;
        if (!ok || lat !== 2 || nwe !== 1 || nre !== 0 || rv !== 2'b01) begin
            n_fail++; $display("FAIL full_store: ok=%0d lat=%0d we=%0d re=%0d rv=%b want 1/2/1/0/01", ok, lat, nwe, nre, rv);
        end
        do_req(0, 1'b0, 32'h11, 32'h0, 4'h0, lat, nre, nwe, rv, rd, err, ok);
        n_cmp++;
        if (!ok || lat !== 2 || rd !== 32'hDEADBEEF || err !== 1'b0 || nre !== 1 || nwe !== 0) begin
            n_fail++; $display("FAIL load_10: ok=%0d lat=%0d rd=%h err=%b re=%0d we=%0d want 1/2/deadbeef/0/1/0", ok, lat, rd, err, nre, nwe);
        end
    endtask

    task automatic test_partial_store();
        int lat, nre, nwe; logic [1:0] rv; logic [31:0] rd; logic err, ok;
        do_req(1, 1'b1, 32'h20, 32'h11223344, 4'hF, lat, nre, nwe, rv, rd, err, ok);
        do_req(1, 1'b1, 32'h20, 32'h0000AA00, 4'b0010, lat, nre, nwe, rv, rd, err, ok);
        n_cmp++;
        if (!ok || lat !== 3 || nre !== 1 || nwe !== 1 || rv !== 2'b10) begin
            n_fail++; $display("FAIL partial_store: ok=%0d lat=%0d re=%0d we=%0d rv=%b want 1/3/1/1/10", ok, lat, nre, nwe, rv);
        end
        n_cmp++;
        if (rd !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL store_rdata_hold: got %h want deadbeef", rd);
        end
        do_req(1, 1'b0, 32'h20, 32'h0, 4'h0, lat, nre, nwe, rv, rd, err, ok);
        n_cmp++;
        if (!ok || rd !== 32'h1122AA44 || lat !== 2) begin
            n_fail++; $display("FAIL partial_reload: ok=%0d rd=%h lat=%0d want 1/1122aa44/2", ok, rd, lat);
        end
    endtask

    task automatic test_round_robin();
        int          ng [2];
        int          gseq[$];
        int          rseq[$];
        logic [31:0] rdq[$];
        logic        g0, g1;
        ng[0] = 0; ng[1] = 0;
        bus.req_we = 2'b00;
        bus.req_addr0 = 32'h10; bus.req_addr1 = 32'h20;
        bus.req_valid = 2'b11;
        for (int i = 0; i < 40 && rseq.size() < 6; i++) begin
            @(negedge clk);
            if (|bus.rsp_valid) begin
                rseq.push_back(bus.rsp_valid == 2'b10 ? 1 : (bus.rsp_valid == 2'b01 ? 0 : 9));
                rdq.push_back(bus.rsp_rdata);
            end
            g0 = bus.req_valid[0] && bus.req_ready[0];
            g1 = bus.req_valid[1] && bus.req_ready[1];
            if (g0) begin gseq.push_back(0); ng[0]++; end
            if (g1) begin gseq.push_back(1); ng[1]++; end
            @(posedge clk); #1;
            if (ng[0] == 3) bus.req_valid[0] = 1'b0;
            if (ng[1] == 3) bus.req_valid[1] = 1'b0;
        end
        bus.req_valid = '0;
        n_cmp++;
        if (gseq.size() !== 6 || rseq.size() !== 6) begin
            n_fail++; $display("FAIL rr_count: grants=%0d rsps=%0d want 6/6", gseq.size(), rseq.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_cmp++;
                if (gseq[i] !== (i % 2) || rseq[i] !== (i % 2)) begin
                    n_fail++; $display("FAIL rr_order[%0d]: grant=%0d rsp=%0d want %0d", i, gseq[i], rseq[i], i % 2);
                end
                n_cmp++;
                if (rdq[i] !== ((i % 2) ? 32'h1122AA44 : 32'hDEADBEEF)) begin
                    n_fail++; $display("FAIL rr_rdata[%0d]: got %h want %h", i, rdq[i], (i % 2) ? 32'h1122AA44 : 32'hDEADBEEF);
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_error();
        int lat, nre, nwe; logic [1:0] rv; logic [31:0] rd; logic err, ok;
        do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, lat, nre, nwe, rv, rd, err, ok);
        do_req(1, 1'b0, 32'h1000, 32'h0, 4'h0, lat, nre, nwe, rv, rd, err, ok);
        n_cmp++;
        if (!ok || err !== 1'b1 || lat !== 2 || rv !== 2'b10) begin
            n_fail++; $display("FAIL err_rsp: ok=%0d err=%b lat=%0d rv=%b want 1/1/2/10", ok, err, lat, rv);
        end
        n_cmp++;
        if (nre !== 0 || nwe !== 0 || rd !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL err_noacc: re=%0d we=%0d rd=%h want 0/0/deadbeef", nre, nwe, rd);
        end
        do_req(1, 1'b0, 32'h20, 32'h0, 4'h0, lat, nre, nwe, rv, rd, err, ok);
        n_cmp++;
        if (err !== 1'b0 || rd !== 32'h1122AA44) begin
            n_fail++; $display("FAIL err_clear: err=%b rd=%h want 0/1122aa44", err, rd);
        end
    endtask

    task automatic test_be_zero();
        int lat, nre, nwe; logic [1:0] rv; logic [31:0] rd; logic err, ok;
        do_req(0, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, lat, nre, nwe, rv, rd, err, ok);
        do_req(0, 1'b1, 32'h40, 32'hFFFFFFFF, 4'h0, lat, nre, nwe, rv, rd, err, ok);
        n_cmp++;
        if (!ok || lat !== 2 || nwe !== 0 || nre !== 0 || err !== 1'b0) begin
            n_fail++; $display("FAIL be0_store: ok=%0d lat=%0d we=%0d re=%0d err=%b want 1/2/0/0/0", ok, lat, nwe, nre, err);
        end
        do_req(1, 1'b0, 32'h40, 32'h0, 4'h0, lat, nre, nwe, rv, rd, err, ok);
        n_cmp++;
        if (rd !== 32'hCAFEF00D) begin
            n_fail++; $display("FAIL be0_reload: got %h want cafef00d", rd);
        end
    endtask

    task automatic test_reset_in_wr();
        int lat, nre, nwe; logic [1:0] rv; logic [31:0] rd; logic err, ok;
        do_req(0, 1'b1, 32'h30, 32'h55667788, 4'hF, lat, nre, nwe, rv, rd, err, ok);
        bus.req_we[0] = 1'b1; bus.req_addr0 = 32'h30; bus.req_wdata0 = 32'h000000EE; bus.req_be0 = 4'b0001;
        bus.req_valid[0] = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.m_RE !== 1'b1 || bus.m_A !== 32'h30) begin
            n_fail++; $display("FAIL rmw_read: RE=%b A=%h want 1/30", bus.m_RE, bus.m_A);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.m_WE !== 1'b1 || bus.m_WD !== 32'h556677EE) begin
            n_fail++; $display("FAIL rmw_write: WE=%b WD=%h want 1/556677ee", bus.m_WE, bus.m_WD);
        end
        Reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.m_RE, bus.m_WE} !== 7'b0 ||
            {bus.rsp_rdata, bus.m_A, bus.m_WD, bus.m_PC} !== 128'b0) begin
            n_fail++; $display("FAIL reset_abort: WE=%b RE=%b A=%h WD=%h rdata=%h want all 0", bus.m_WE, bus.m_RE, bus.m_A, bus.m_WD, bus.rsp_rdata);
        end
        @(posedge clk); #1;
        Reset_n = 1'b1;
        @(posedge clk); #1;
        do_req(1, 1'b0, 32'h30, 32'h0, 4'h0, lat, nre, nwe, rv, rd, err, ok);
        n_cmp++;
        if (!ok || rd !== 32'h55667788) begin
            n_fail++; $display("FAIL reset_keep: ok=%0d rd=%h want 1/55667788", ok, rd);
        end
    endtask

    initial begin
        cyc = 0; n_cmp = 0; n_fail = 0;
        test_reset();
        test_full_store_load();
        test_partial_store();
        test_round_robin();
        test_error();
        test_be_zero();
        test_reset_in_wr();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
